// File: rtl/fib_run_ctrl.sv
// fib_run_ctrl: Wishbone-programmable run scheduler for the fibonacci engine.
// It clears the engine, issues step pulses at a programmed rate, counts steps,
// detects wrap-around overflow of the engine value, snapshots the final value
// and raises a level interrupt when a run completes.
module fib_run_ctrl #(
    parameter int VALUE_WIDTH = 30,
    parameter int DIV_WIDTH   = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   fib_clear_o,
    output logic                   fib_step_o,
    input  logic [VALUE_WIDTH-1:0] fib_value_i,
    output logic                   irq_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                 state;

    // Programmable configuration
    logic [DIV_WIDTH-1:0]   prescale;
    logic [CNT_WIDTH-1:0]   count;
    logic                   continuous;
    logic                   irq_en;

    // Run bookkeeping
    logic [DIV_WIDTH-1:0]   presc;
    logic [CNT_WIDTH-1:0]   remaining;
    logic [VALUE_WIDTH-1:0] last;
    logic [VALUE_WIDTH-1:0] snapshot;

    // Status flags
    logic                   done;
    logic                   overflow;
    logic                   stopped;

    // Bus decode
    logic                   wb_fire;
    logic                   wr_fire;
    logic                   wr_ctrl;
    logic                   cmd_start;
    logic                   cmd_stop;
    logic                   cmd_done_clr;
    logic                   busy;
    logic [31:0]            rd_data;
    logic                   unused_bits;

    // A new access is accepted only when no ack is pending, so ack never
    // appears in two consecutive cycles and each access is serviced once.
    assign wb_fire      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr_fire      = wb_fire & wbs_we_i;
    assign wr_ctrl      = wr_fire & (wbs_adr_i[3:2] == 2'd0);
    // Stop dominates start when both arrive in the same write.
    assign cmd_start    = wr_ctrl & wbs_dat_i[0] & ~wbs_dat_i[1];
    assign cmd_stop     = wr_ctrl & wbs_dat_i[1];
    assign cmd_done_clr = wr_ctrl & wbs_dat_i[4];

    assign busy  = (state == S_CLEAR) | (state == S_RUN) | (state == S_CHECK);
    assign irq_o = done & irq_en;

    // Byte-lane bits of the address and upper data bits carry no information.
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

    // Read-data selection from the word index.
    always_comb begin
        rd_data = '0;
        case (wbs_adr_i[3:2])
            2'd0:    rd_data = {26'd0, continuous, irq_en, stopped, overflow, done, busy};
            2'd1:    rd_data = 32'(prescale);
            2'd2:    rd_data = 32'(count);
            default: rd_data = 32'(snapshot);
        endcase
    end

    // Single-cycle acknowledge with read data registered alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wb_fire;
            wbs_dat_o <= (wb_fire && !wbs_we_i) ? rd_data : 32'd0;
        end
    end

    // Configuration registers; run parameters are frozen while a run is active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale   <= '0;
            count      <= '0;
            continuous <= 1'b0;
            irq_en     <= 1'b0;
        end else if (wr_fire) begin
            case (wbs_adr_i[3:2])
                2'd0: begin
                    irq_en <= wbs_dat_i[3];
                    if (!busy) begin
                        continuous <= wbs_dat_i[2];
                    end
                end
                2'd1: begin
                    if (!busy) begin
                        prescale <= wbs_dat_i[DIV_WIDTH-1:0];
                    end
                end
                2'd2: begin
                    if (!busy) begin
                        count <= wbs_dat_i[CNT_WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Run sequencer. The step pulse is registered so that it is high during
    // the RUN cycle whose prescaler value is zero; CHECK then sees the new
    // engine value one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            presc       <= '0;
            remaining   <= '0;
            last        <= '0;
            snapshot    <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            stopped     <= 1'b0;
            fib_clear_o <= 1'b0;
            fib_step_o  <= 1'b0;
        end else begin
            fib_clear_o <= 1'b0;
            fib_step_o  <= 1'b0;

            // The DONE branch below overrides this, so a clear racing the
            // completion cycle leaves done set.
            if (cmd_done_clr) begin
                done <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        state       <= S_CLEAR;
                        fib_clear_o <= 1'b1;
                        done        <= 1'b0;
                        overflow    <= 1'b0;
                        stopped     <= 1'b0;
                        remaining   <= count;
                        last        <= '0;
                    end
                end

                S_CLEAR: begin
                    if (cmd_stop) begin
                        state   <= S_DONE;
                        stopped <= 1'b1;
                    end else begin
                        presc <= prescale;
                        if ((remaining == '0) && !continuous) begin
                            state <= S_DONE;
                        end else begin
                            state      <= S_RUN;
                            fib_step_o <= (prescale == '0);
                        end
                    end
                end

                S_RUN: begin
                    if (cmd_stop) begin
                        state   <= S_DONE;
                        stopped <= 1'b1;
                    end else if (presc != '0) begin
                        presc      <= presc - DIV_WIDTH'(1);
                        fib_step_o <= (presc == DIV_WIDTH'(1));
                    end else begin
                        state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (cmd_stop) begin
                        state   <= S_DONE;
                        stopped <= 1'b1;
                    end else if (fib_value_i < last) begin
                        // Engine value wrapped: the term no longer fits.
                        overflow <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        last <= fib_value_i;
                        if (!continuous && (remaining != '0)) begin
                            remaining <= remaining - CNT_WIDTH'(1);
                        end
                        if (!continuous && (remaining == CNT_WIDTH'(1))) begin
                            state <= S_DONE;
                        end else begin
                            presc      <= prescale;
                            state      <= S_RUN;
                            fib_step_o <= (prescale == '0);
                        end
                    end
                end

                S_DONE: begin
                    snapshot <= fib_value_i;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_run_ctrl.sv
// Testbench for fib_run_ctrl with an 8-bit fibonacci engine model.
module tb_fib_run_ctrl;

    localparam int VW = 8;
    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wbs_stb_i = 1'b0;
    logic          wbs_cyc_i = 1'b0;
    logic          wbs_we_i = 1'b0;
    logic [3:0]    wbs_adr_i = '0;
    logic [31:0]   wbs_dat_i = '0;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          fib_clear_o;
    logic          fib_step_o;
    logic          irq_o;
    logic [VW-1:0] fib_value;

    int total = 0;
    int bad = 0;

    // Scoreboard of expected engine values, one per step
    logic [VW-1:0] exp_q[$];

    // Monitor records
    int            cyc = 0;
    int            step_cyc[$];
    int            clear_cyc[$];
    int            irq_cyc[$];
    logic [VW-1:0] obs_val[$];
    logic          step_prev = 1'b0;
    logic          irq_prev = 1'b0;

    always #5 clk = ~clk;

    fib_run_ctrl #(
        .VALUE_WIDTH(VW),
        .DIV_WIDTH  (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .fib_clear_o(fib_clear_o),
        .fib_step_o (fib_step_o),
        .fib_value_i(fib_value),
        .irq_o      (irq_o)
    );

    // Engine model: clear seeds (0,1); each step advances one term
    logic [VW-1:0] fa, fb;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fa <= '0;
            fb <= 8'd1;
        end else if (fib_clear_o) begin
            fa <= '0;
            fb <= 8'd1;
        end else if (fib_step_o) begin
            fa <= fb;
            fb <= fa + fb;
        end
    end
    assign fib_value = fa;

    // Monitor sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (step_prev) obs_val.push_back(fib_value);
        step_prev = fib_step_o;
        if (fib_clear_o) clear_cyc.push_back(cyc);
        if (fib_step_o) step_cyc.push_back(cyc);
        if (irq_o && !irq_prev) irq_cyc.push_back(cyc);
        irq_prev = irq_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic wb_cycle(input logic we, input logic [3:0] a, input logic [31:0] d,
                            output logic [31:0] q);
        int t;
        @(negedge clk);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = a;
        wbs_dat_i = d;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!wbs_ack_o && t < 8);
        q = wbs_dat_o;
        if (!wbs_ack_o) begin
            total++;
            bad++;
            $display("FAIL wb_ack_timeout adr=%0h: no ack, required ack within 8 cycles", a);
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_cycle(1'b1, a, d, q);
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] q);
        wb_cycle(1'b0, a, 32'd0, q);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_fib(input int n);
        logic [VW-1:0] ea, eb, et;
        ea = '0;
        eb = 8'd1;
        for (int i = 0; i < n; i++) begin
            et = eb;
            eb = ea + eb;
            ea = et;
            exp_q.push_back(ea);
        end
    endtask

    task automatic test_reset();
        logic [31:0] q;
        reset_n = 1'b0;
        wait_cycles(3);
        total++;
        if ({wbs_ack_o, fib_clear_o, fib_step_o, irq_o} !== 4'b0000 || wbs_dat_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs got ack=%b clr=%b step=%b irq=%b dat=%h, required all 0",
                     wbs_ack_o, fib_clear_o, fib_step_o, irq_o, wbs_dat_o);
        end
        reset_n = 1'b1;
        wait_cycles(2);
        for (int r = 0; r < 4; r++) begin
            wb_read(4'(r * 4), q);
            total++;
            if (q !== 32'd0) begin
                bad++;
                $display("FAIL reset_reg%0d got %h, required 0", r, q);
            end
        end
        total++;
        if (irq_o !== 1'b0 || fib_step_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq_step got irq=%b step=%b, required 0 0", irq_o, fib_step_o);
        end
    endtask

    task automatic test_counted_run();
        logic [31:0]   q;
        logic [VW-1:0] e;
        int sb, cb, ob, t, gap;
        sb = step_cyc.size();
        cb = clear_cyc.size();
        ob = obs_val.size();
        push_fib(10);
        wb_write(4'h4, 32'd3);
        wb_write(4'h8, 32'd10);
        wb_write(4'h0, 32'h9);
        t = 0;
        while (!irq_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (irq_o !== 1'b1) begin
            bad++;
            $display("FAIL run_irq got irq=%b, required 1", irq_o);
        end
        wait_cycles(5);
        total++;
        if (clear_cyc.size() - cb !== 1) begin
            bad++;
            $display("FAIL run_clear_count got %0d, required 1", clear_cyc.size() - cb);
        end
        total++;
        if (step_cyc.size() - sb !== 10) begin
            bad++;
            $display("FAIL run_step_count got %0d, required 10", step_cyc.size() - sb);
        end
        if (clear_cyc.size() > cb && step_cyc.size() >= sb + 10) begin
            total++;
            gap = step_cyc[sb] - clear_cyc[cb];
            if (gap !== 4) begin
                bad++;
                $display("FAIL run_first_step got %0d cycles after clear, required 4", gap);
            end
            for (int i = 1; i < 10; i++) begin
                total++;
                gap = step_cyc[sb + i] - step_cyc[sb + i - 1];
                if (gap !== 5) begin
                    bad++;
                    $display("FAIL run_step_gap%0d got %0d, required 5", i, gap);
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_val.size() <= ob + i) begin
                bad++;
                $display("FAIL run_value%0d got none, required %0d", i, e);
            end else if (obs_val[ob + i] !== e) begin
                bad++;
                $display("FAIL run_value%0d got %0d, required %0d", i, obs_val[ob + i], e);
            end
        end
        wb_read(4'hC, q);
        total++;
        if (q !== 32'd55) begin
            bad++;
            $display("FAIL run_snapshot got %0d, required 55", q);
        end
        wb_read(4'h0, q);
        total++;
        if (q !== 32'h12) begin
            bad++;
            $display("FAIL run_ctrl got %h, required 12", q);
        end
        wb_read(4'h4, q);
        total++;
        if (q !== 32'd3) begin
            bad++;
            $display("FAIL run_prescale got %0d, required 3", q);
        end
        wb_write(4'h0, 32'h18);
        total++;
        if (irq_o !== 1'b0) begin
            bad++;
            $display("FAIL run_done_clr_irq got %b, required 0", irq_o);
        end
        wb_read(4'h0, q);
        total++;
        if (q !== 32'h10) begin
            bad++;
            $display("FAIL run_done_clr_ctrl got %h, required 10", q);
        end
    endtask

    task automatic test_continuous_overflow();
        logic [31:0]   q;
        logic [VW-1:0] e;
        int sb, ob, t;
        sb = step_cyc.size();
        ob = obs_val.size();
        push_fib(14);
        wb_write(4'h4, 32'd0);
        wb_write(4'h0, 32'h5);
        t = 0;
        q = 32'd0;
        while (q[1] !== 1'b1 && t < 100) begin
            wb_read(4'h0, q);
            t++;
        end
        wait_cycles(10);
        total++;
        if (step_cyc.size() - sb !== 14) begin
            bad++;
            $display("FAIL cont_step_count got %0d, required 14", step_cyc.size() - sb);
        end
        for (int i = 0; i < 14; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_val.size() <= ob + i) begin
                bad++;
                $display("FAIL cont_value%0d got none, required %0d", i, e);
            end else if (obs_val[ob + i] !== e) begin
                bad++;
                $display("FAIL cont_value%0d got %0d, required %0d", i, obs_val[ob + i], e);
            end
        end
        wb_read(4'hC, q);
        total++;
        if (q !== 32'd121) begin
            bad++;
            $display("FAIL cont_snapshot got %0d, required 121", q);
        end
        wb_read(4'h0, q);
        total++;
        if (q !== 32'h26) begin
            bad++;
            $display("FAIL cont_ctrl got %h, required 26", q);
        end
    endtask

    task automatic test_count_zero();
        logic [31:0] q;
        int sb, cb, ib;
        sb = step_cyc.size();
        cb = clear_cyc.size();
        ib = irq_cyc.size();
        wb_write(4'h8, 32'd0);
        wb_write(4'h0, 32'h9);
        wait_cycles(10);
        total++;
        if (clear_cyc.size() - cb !== 1) begin
            bad++;
            $display("FAIL zero_clear_count got %0d, required 1", clear_cyc.size() - cb);
        end
        total++;
        if (step_cyc.size() - sb !== 0) begin
            bad++;
            $display("FAIL zero_step_count got %0d, required 0", step_cyc.size() - sb);
        end
        total++;
        if (irq_cyc.size() <= ib || clear_cyc.size() <= cb) begin
            bad++;
            $display("FAIL zero_done_timing got no irq edge, required irq 2 cycles after clear");
        end else if (irq_cyc[ib] - clear_cyc[cb] !== 2) begin
            bad++;
            $display("FAIL zero_done_timing got %0d, required 2", irq_cyc[ib] - clear_cyc[cb]);
        end
        wb_read(4'hC, q);
        total++;
        if (q !== 32'd0) begin
            bad++;
            $display("FAIL zero_snapshot got %0d, required 0", q);
        end
        wb_read(4'h0, q);
        total++;
        if (q !== 32'h12) begin
            bad++;
            $display("FAIL zero_ctrl got %h, required 12", q);
        end
        wb_write(4'h0, 32'h10);
    endtask

    task automatic test_stop();
        logic [31:0] q;
        int sb, cb, t;
        sb = step_cyc.size();
        wb_write(4'h4, 32'd20);
        wb_write(4'h8, 32'd100);
        wb_write(4'h0, 32'h1);
        t = 0;
        while (step_cyc.size() - sb < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        wb_write(4'h0, 32'h2);
        wait_cycles(80);
        total++;
        if (step_cyc.size() - sb !== 3) begin
            bad++;
            $display("FAIL stop_step_count got %0d, required 3", step_cyc.size() - sb);
        end
        wb_read(4'h0, q);
        total++;
        if (q !== 32'h0A) begin
            bad++;
            $display("FAIL stop_ctrl got %h, required 0a", q);
        end
        wb_read(4'hC, q);
        total++;
        if (q !== 32'd2) begin
            bad++;
            $display("FAIL stop_snapshot got %0d, required 2", q);
        end
        cb = clear_cyc.size();
        wb_write(4'h0, 32'h3);
        wait_cycles(10);
        total++;
        if (clear_cyc.size() - cb !== 0) begin
            bad++;
            $display("FAIL start_stop_clear got %0d pulses, required 0", clear_cyc.size() - cb);
        end
        wb_read(4'h0, q);
        total++;
        if (q !== 32'h0A) begin
            bad++;
            $display("FAIL start_stop_ctrl got %h, required 0a", q);
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] q;
        int sb, cb, t;
        sb = step_cyc.size();
        cb = clear_cyc.size();
        wb_write(4'h4, 32'd10);
        wb_write(4'h8, 32'd50);
        wb_write(4'h0, 32'h1);
        t = 0;
        while (step_cyc.size() - sb < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        wb_write(4'h8, 32'd5);
        wb_write(4'h0, 32'h1);
        wait_cycles(5);
        total++;
        if (clear_cyc.size() - cb !== 1) begin
            bad++;
            $display("FAIL busy_restart got %0d clear pulses, required 1", clear_cyc.size() - cb);
        end
        wb_read(4'h8, q);
        total++;
        if (q !== 32'd50) begin
            bad++;
            $display("FAIL busy_count got %0d, required 50", q);
        end
        wb_read(4'h0, q);
        total++;
        if (q[0] !== 1'b1) begin
            bad++;
            $display("FAIL busy_flag got %b, required 1", q[0]);
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (fib_step_o !== 1'b1 && t < 40);
        total++;
        if (fib_step_o !== 1'b1) begin
            bad++;
            $display("FAIL busy_step_wait got no step, required step within 40 cycles");
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({wbs_ack_o, fib_clear_o, fib_step_o, irq_o} !== 4'b0000 || wbs_dat_o !== 32'd0) begin
            bad++;
            $display("FAIL midrun_reset got ack=%b clr=%b step=%b irq=%b dat=%h, required all 0",
                     wbs_ack_o, fib_clear_o, fib_step_o, irq_o, wbs_dat_o);
        end
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(2);
        wb_read(4'h0, q);
        total++;
        if (q !== 32'd0) begin
            bad++;
            $display("FAIL midrun_ctrl got %h, required 0", q);
        end
        wb_read(4'h8, q);
        total++;
        if (q !== 32'd0) begin
            bad++;
            $display("FAIL midrun_count got %0d, required 0", q);
        end
    endtask

    initial begin
        test_reset();
        test_counted_run();
        test_continuous_overflow();
        test_count_zero();
        test_stop();
        test_busy_writes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
